// File: rtl/fp_ex_seq.sv
// Execute-stage FP sequencer: issues decoded FP ops to the external datapath, stalls decode
// until completion, and registers result/rd/flags into EX_MEM. Define FP_FWD_EN for operand forwarding.
module fp_ex_seq #(
  parameter int LAT_ADD     = 3,
  parameter int LAT_MUL     = 4,
  parameter int LAT_MISC    = 1,
  parameter int DIV_TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        Rst,
  input  logic        ID_EX_fpusrc,
  input  logic [4:0]  ID_EX_fpusel,
  input  logic [2:0]  ID_EX_frm,
  input  logic [4:0]  ID_EX_rd,
`ifdef FP_FWD_EN
  input  logic [4:0]  ID_EX_rs1,
  input  logic [4:0]  ID_EX_rs2,
  input  logic [4:0]  ID_EX_rs3,
`endif
  input  logic [31:0] ID_EX_dout_rs1,
  input  logic [31:0] ID_EX_dout_rs2,
  input  logic [31:0] ID_EX_dout_rs3,
  input  logic [2:0]  fcsr_frm,
  input  logic        mem_hold,
  input  logic        fflags_clr,
  output logic        fpu_start,
  output logic [4:0]  fpu_op,
  output logic [2:0]  fpu_rm,
  output logic [31:0] fpu_a,
  output logic [31:0] fpu_b,
  output logic [31:0] fpu_c,
  input  logic [31:0] fpu_res,
  input  logic [4:0]  fpu_flags,
  input  logic        fpu_done,
  output logic        f_stall,
  output logic [31:0] EX_MEM_fpures,
  output logic [4:0]  EX_MEM_fprd,
  output logic        EX_MEM_fpusrc,
  output logic [4:0]  fflags_acc,
  output logic        illegal_rm,
  output logic        fpu_timeout
);

  localparam int MAX_FIX = (LAT_ADD > LAT_MUL) ? ((LAT_ADD > LAT_MISC) ? LAT_ADD : LAT_MISC)
                                               : ((LAT_MUL > LAT_MISC) ? LAT_MUL : LAT_MISC);
  localparam int MAX_LAT = (MAX_FIX > DIV_TIMEOUT) ? MAX_FIX : DIV_TIMEOUT;
  localparam int CW      = $clog2(MAX_LAT + 1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [31:0]   QNAN    = 32'h7FC0_0000;
  localparam logic [4:0]    FLAG_NV = 5'b10000;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_WAITD, S_HOLD} state_t;

  state_t        r_state, w_next;
  logic [CW-1:0] r_cnt, w_cnt_next;
  logic [2:0]    w_rm;
  logic          w_rm_bad, w_is_div, w_issue, w_start;
  logic          w_fin_illegal, w_fin_fast, w_timeout, w_finish, w_write;
  logic [4:0]    w_new_flags;
  logic [31:0]   w_a, w_b, w_c;
  int            w_lat;

  always_comb begin
    unique case (ID_EX_fpusel)
      5'd0, 5'd1:                    w_lat = LAT_ADD;
      5'd2, 5'd8, 5'd9, 5'd10, 5'd11: w_lat = LAT_MUL;
      default:                       w_lat = LAT_MISC;
    endcase
  end

  assign w_rm     = (ID_EX_frm == 3'b111) ? fcsr_frm : ID_EX_frm;
  assign w_rm_bad = (w_rm == 3'd5) || (w_rm == 3'd6);
  assign w_is_div = (ID_EX_fpusel == 5'd3) || (ID_EX_fpusel == 5'd4);
  // Gated by reset so every output, including the combinational stall, reads 0 while in reset.
  assign w_issue  = Rst && (r_state == S_IDLE) && ID_EX_fpusrc;
  assign w_start  = w_issue && !w_rm_bad;

  assign w_fin_illegal = w_issue && w_rm_bad;
  assign w_fin_fast    = w_start && !w_is_div && (w_lat == 1);
  assign w_timeout     = (r_state == S_WAITD) && !fpu_done && (r_cnt == CNT_ONE);
  assign w_finish      = w_fin_illegal || w_fin_fast
                      || ((r_state == S_BUSY)  && (r_cnt == CNT_ONE))
                      || ((r_state == S_WAITD) && (fpu_done || (r_cnt == CNT_ONE)));
  assign w_write       = w_finish && !w_fin_illegal;
  assign w_new_flags   = !w_write ? 5'b0 : (w_timeout ? FLAG_NV : fpu_flags);

  assign f_stall = (w_issue || (r_state == S_BUSY) || (r_state == S_WAITD)) && !w_finish;

`ifdef FP_FWD_EN
  logic r_prev_wr;

  always_ff @(posedge clk or negedge Rst) begin
    if (!Rst)          r_prev_wr <= 1'b0;
    else if (w_finish) r_prev_wr <= w_write;
  end

  always_comb begin
    w_a = (r_prev_wr && (ID_EX_rs1 == EX_MEM_fprd)) ? EX_MEM_fpures : ID_EX_dout_rs1;
    w_b = (r_prev_wr && (ID_EX_rs2 == EX_MEM_fprd)) ? EX_MEM_fpures : ID_EX_dout_rs2;
    w_c = (r_prev_wr && (ID_EX_rs3 == EX_MEM_fprd)) ? EX_MEM_fpures : ID_EX_dout_rs3;
  end
`else
  always_comb begin
    w_a = ID_EX_dout_rs1;
    w_b = ID_EX_dout_rs2;
    w_c = ID_EX_dout_rs3;
  end
`endif

  always_comb begin
    // NOTE: defaults first so every path assigns w_next/w_cnt_next and no latch is inferred.
    w_next     = r_state;
    w_cnt_next = r_cnt;
    unique case (r_state)
      S_IDLE: begin
        if (w_issue) begin
          if (w_finish) begin
            w_next = mem_hold ? S_HOLD : S_IDLE;
          end else if (w_is_div) begin
            w_next     = S_WAITD;
            w_cnt_next = CW'(DIV_TIMEOUT - 1);
          end else begin
            w_next     = S_BUSY;
            w_cnt_next = CW'(w_lat - 1);
          end
        end
      end
      S_BUSY, S_WAITD: begin
        if (w_finish) begin
          w_next     = mem_hold ? S_HOLD : S_IDLE;
          w_cnt_next = '0;
        end else begin
          w_cnt_next = r_cnt - CNT_ONE;
        end
      end
      S_HOLD: if (!mem_hold) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge Rst) begin
    if (!Rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      // NOTE: non-blocking assignments so all registers update from the same pre-edge values.
      r_state <= w_next;
      r_cnt   <= w_cnt_next;
    end
  end

  always_ff @(posedge clk or negedge Rst) begin
    if (!Rst) begin
      fpu_start     <= 1'b0;
      fpu_op        <= '0;
      fpu_rm        <= '0;
      fpu_a         <= '0;
      fpu_b         <= '0;
      fpu_c         <= '0;
      EX_MEM_fpures <= '0;
      EX_MEM_fprd   <= '0;
      EX_MEM_fpusrc <= 1'b0;
      fflags_acc    <= '0;
      illegal_rm    <= 1'b0;
      fpu_timeout   <= 1'b0;
    end else begin
      fpu_start   <= w_start;
      illegal_rm  <= w_fin_illegal;
      fpu_timeout <= w_timeout;
      if (w_start) begin
        fpu_op <= ID_EX_fpusel;
        fpu_rm <= w_rm;
        fpu_a  <= w_a;
        fpu_b  <= w_b;
        fpu_c  <= w_c;
      end
      // Decode holds ID_EX until the finishing cycle, so ID_EX_rd still names this op's target.
      if (w_write) begin
        EX_MEM_fpures <= w_timeout ? QNAN : fpu_res;
        EX_MEM_fprd   <= ID_EX_rd;
        EX_MEM_fpusrc <= 1'b1;
      end else if (!((r_state == S_HOLD) && mem_hold)) begin
        EX_MEM_fpusrc <= 1'b0;
      end
      fflags_acc <= fflags_clr ? w_new_flags : (fflags_acc | w_new_flags);
    end
  end

endmodule

// File: tb/tb_fp_ex_seq.sv
// Self-checking bench for fp_ex_seq: directed vector table, random ops against a timeline
// reference model, and a hand-written reset-during-BUSY sequence.
module tb_fp_ex_seq;
  localparam int LAT_ADD = 3, LAT_MUL = 4, LAT_MISC = 1, DT = 64;

  logic        clk = 1'b0, Rst = 1'b0;
  logic        ID_EX_fpusrc = 1'b0;
  logic [4:0]  ID_EX_fpusel = '0, ID_EX_rd = '0;
  logic [2:0]  ID_EX_frm = '0, fcsr_frm = '0;
  logic [31:0] ID_EX_dout_rs1 = '0, ID_EX_dout_rs2 = '0, ID_EX_dout_rs3 = '0;
  logic        mem_hold = 1'b0, fflags_clr = 1'b0, fpu_done = 1'b0;
  logic [31:0] fpu_res = '0;
  logic [4:0]  fpu_flags = '0;
  logic        fpu_start, f_stall, EX_MEM_fpusrc, illegal_rm, fpu_timeout;
  logic [4:0]  fpu_op, EX_MEM_fprd, fflags_acc;
  logic [2:0]  fpu_rm;
  logic [31:0] fpu_a, fpu_b, fpu_c, EX_MEM_fpures;
`ifdef FP_FWD_EN
  logic [4:0]  ID_EX_rs1 = '0, ID_EX_rs2 = '0, ID_EX_rs3 = '0;
`endif

  fp_ex_seq #(.LAT_ADD(LAT_ADD), .LAT_MUL(LAT_MUL), .LAT_MISC(LAT_MISC), .DIV_TIMEOUT(DT)) dut (
    .clk(clk), .Rst(Rst), .ID_EX_fpusrc(ID_EX_fpusrc), .ID_EX_fpusel(ID_EX_fpusel),
    .ID_EX_frm(ID_EX_frm), .ID_EX_rd(ID_EX_rd),
`ifdef FP_FWD_EN
    .ID_EX_rs1(ID_EX_rs1), .ID_EX_rs2(ID_EX_rs2), .ID_EX_rs3(ID_EX_rs3),
`endif
    .ID_EX_dout_rs1(ID_EX_dout_rs1), .ID_EX_dout_rs2(ID_EX_dout_rs2), .ID_EX_dout_rs3(ID_EX_dout_rs3),
    .fcsr_frm(fcsr_frm), .mem_hold(mem_hold), .fflags_clr(fflags_clr),
    .fpu_start(fpu_start), .fpu_op(fpu_op), .fpu_rm(fpu_rm),
    .fpu_a(fpu_a), .fpu_b(fpu_b), .fpu_c(fpu_c),
    .fpu_res(fpu_res), .fpu_flags(fpu_flags), .fpu_done(fpu_done),
    .f_stall(f_stall), .EX_MEM_fpures(EX_MEM_fpures), .EX_MEM_fprd(EX_MEM_fprd),
    .EX_MEM_fpusrc(EX_MEM_fpusrc), .fflags_acc(fflags_acc),
    .illegal_rm(illegal_rm), .fpu_timeout(fpu_timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  sel;
    logic [2:0]  frm, fcsr;
    logic [4:0]  rd;
    logic [31:0] a, b, c, res;
    logic [4:0]  flags;
    int          done_at;   // cycle index (issue = 0) at which fpu_done pulses; -1 = never
    int          hold;      // cycles of mem_hold starting at the finishing cycle
    bit          clr;       // pulse fflags_clr in the finishing cycle
    int          exp_k;     // expected finishing cycle index
    bit          exp_wr;    // op writes EX_MEM (legal rounding mode)
    bit          exp_to;    // expected timeout
    logic [31:0] exp_res;
    logic [4:0]  exp_fl;
  } vec_t;

  int         checks = 0, errors = 0, cur_id = 0;
  logic [4:0] m_acc = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s (vec %0d): got %h expected %h", name, cur_id, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [4:0] sel, input logic [2:0] frm, fcsr,
                              input logic [4:0] rd, input logic [31:0] a, b, c, res,
                              input logic [4:0] fl, input int done_at, hold, input bit clr,
                              input int ek, input bit ewr, eto,
                              input logic [31:0] eres, input logic [4:0] efl);
    vec_t v;
    v.sel = sel; v.frm = frm; v.fcsr = fcsr; v.rd = rd;
    v.a = a; v.b = b; v.c = c; v.res = res; v.flags = fl;
    v.done_at = done_at; v.hold = hold; v.clr = clr;
    v.exp_k = ek; v.exp_wr = ewr; v.exp_to = eto; v.exp_res = eres; v.exp_fl = efl;
    return v;
  endfunction

  // Reference: derives the completion timeline and outcome from the op class and handshake.
  function automatic vec_t ref_model(input vec_t v);
    logic [2:0] rm;
    int lat;
    rm = (v.frm == 3'd7) ? v.fcsr : v.frm;
    if (v.sel inside {5'd0, 5'd1})                          lat = LAT_ADD;
    else if (v.sel inside {5'd2, 5'd8, 5'd9, 5'd10, 5'd11}) lat = LAT_MUL;
    else                                                    lat = LAT_MISC;
    v.exp_to = 1'b0; v.exp_res = v.res; v.exp_fl = v.flags; v.exp_wr = 1'b1;
    if (rm == 3'd5 || rm == 3'd6) begin
      v.exp_k = 0; v.exp_wr = 1'b0; v.exp_res = '0; v.exp_fl = '0;
    end else if (v.sel == 5'd3 || v.sel == 5'd4) begin
      if (v.done_at >= 1 && v.done_at <= DT - 1) v.exp_k = v.done_at;
      else begin
        v.exp_k = DT - 1; v.exp_to = 1'b1; v.exp_res = 32'h7FC0_0000; v.exp_fl = 5'b10000;
      end
    end else begin
      v.exp_k = lat - 1;
    end
    return v;
  endfunction

  task automatic run_vec(input vec_t v);
    int k, last_drv, e;
    logic [2:0] rm;
    logic [4:0] acc_after;
    k        = v.exp_k;
    last_drv = (v.hold > 0) ? k + v.hold : k;
    e        = k + ((v.hold > 1) ? v.hold : 1);
    rm       = (v.frm == 3'd7) ? v.fcsr : v.frm;
    acc_after = v.clr ? v.exp_fl : (m_acc | v.exp_fl);
    for (int t = 0; t <= e + 1; t++) begin
      @(posedge clk); #1;
      ID_EX_fpusrc   = (t <= last_drv);
      ID_EX_fpusel   = v.sel;  ID_EX_frm = v.frm;  fcsr_frm = v.fcsr;  ID_EX_rd = v.rd;
      ID_EX_dout_rs1 = v.a;    ID_EX_dout_rs2 = v.b;  ID_EX_dout_rs3 = v.c;
      mem_hold   = (v.hold > 0) && (t >= k) && (t < k + v.hold);
      fflags_clr = v.clr && (t == k);
      fpu_done   = (t == v.done_at);
      fpu_res    = (t == k) ? v.res : ~v.res;
      fpu_flags  = (t == k) ? v.flags : ~v.flags;
      #1;
      check("f_stall",       f_stall,       t < k);
      check("fpu_start",     fpu_start,     v.exp_wr && t == 1);
      check("EX_MEM_fpusrc", EX_MEM_fpusrc, v.exp_wr && t > k && t <= e);
      check("illegal_rm",    illegal_rm,    !v.exp_wr && t == k + 1);
      check("fpu_timeout",   fpu_timeout,   v.exp_to && t == k + 1);
      check("fflags_acc",    fflags_acc,    (t > k) ? acc_after : m_acc);
      if (v.exp_wr && t == 1) begin
        check("fpu_op", fpu_op, v.sel);
        check("fpu_rm", fpu_rm, rm);
        check("fpu_a",  fpu_a,  v.a);
        check("fpu_b",  fpu_b,  v.b);
        check("fpu_c",  fpu_c,  v.c);
      end
      if (v.exp_wr && t > k && t <= e) begin
        check("EX_MEM_fpures", EX_MEM_fpures, v.exp_res);
        check("EX_MEM_fprd",   EX_MEM_fprd,   v.rd);
      end
    end
    m_acc = acc_after;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " fpu_start"},     fpu_start,     0);
    check({tag, " fpu_op"},        fpu_op,        0);
    check({tag, " fpu_rm"},        fpu_rm,        0);
    check({tag, " fpu_a"},         fpu_a,         0);
    check({tag, " fpu_b"},         fpu_b,         0);
    check({tag, " fpu_c"},         fpu_c,         0);
    check({tag, " f_stall"},       f_stall,       0);
    check({tag, " EX_MEM_fpures"}, EX_MEM_fpures, 0);
    check({tag, " EX_MEM_fprd"},   EX_MEM_fprd,   0);
    check({tag, " EX_MEM_fpusrc"}, EX_MEM_fpusrc, 0);
    check({tag, " fflags_acc"},    fflags_acc,    0);
    check({tag, " illegal_rm"},    illegal_rm,    0);
    check({tag, " fpu_timeout"},   fpu_timeout,   0);
  endtask

  vec_t dir_tab[13];
  vec_t rv;

  initial begin
    dir_tab[0]  = mk(5'd0, 3'd0, 3'd0, 5'd3, 32'h3F800000, 32'h40000000, 32'h0, 32'h40400000, 5'b00001,
                     -1, 0, 1'b0, 2, 1'b1, 1'b0, 32'h40400000, 5'b00001);
    dir_tab[1]  = mk(5'd6, 3'd0, 3'd0, 5'd4, 32'h3F800000, 32'h40000000, 32'h0, 32'h40000000, 5'b00000,
                     0, 0, 1'b0, 0, 1'b1, 1'b0, 32'h40000000, 5'b00000);
    dir_tab[2]  = mk(5'd3, 3'd1, 3'd0, 5'd5, 32'h3F800000, 32'h40000000, 32'h0, 32'h3F000000, 5'b01000,
                     10, 0, 1'b0, 10, 1'b1, 1'b0, 32'h3F000000, 5'b01000);
    dir_tab[3]  = mk(5'd3, 3'd1, 3'd0, 5'd6, 32'h40800000, 32'h40000000, 32'h0, 32'h40000000, 5'b00000,
                     9, 0, 1'b0, 9, 1'b1, 1'b0, 32'h40000000, 5'b00000);
    dir_tab[4]  = mk(5'd3, 3'd2, 3'd0, 5'd7, 32'h41000000, 32'h40000000, 32'h0, 32'h40800000, 5'b00001,
                     11, 0, 1'b0, 11, 1'b1, 1'b0, 32'h40800000, 5'b00001);
    dir_tab[5]  = mk(5'd4, 3'd0, 3'd0, 5'd8, 32'hBF800000, 32'h0, 32'h0, 32'h12345678, 5'b00010,
                     -1, 0, 1'b0, 63, 1'b1, 1'b1, 32'h7FC00000, 5'b10000);
    dir_tab[6]  = mk(5'd0, 3'd7, 3'd5, 5'd9, 32'h3F800000, 32'h3F800000, 32'h0, 32'h40000000, 5'b00001,
                     -1, 0, 1'b0, 0, 1'b0, 1'b0, 32'h0, 5'b00000);
    dir_tab[7]  = mk(5'd2, 3'd7, 3'd2, 5'd10, 32'h40000000, 32'h40400000, 32'h0, 32'h40C00000, 5'b00001,
                     -1, 4, 1'b0, 3, 1'b1, 1'b0, 32'h40C00000, 5'b00001);
    dir_tab[8]  = mk(5'd9, 3'd4, 3'd0, 5'd11, 32'h40000000, 32'h40400000, 32'h3F800000, 32'h40E00000, 5'b00100,
                     -1, 0, 1'b1, 3, 1'b1, 1'b0, 32'h40E00000, 5'b00100);
    dir_tab[9]  = mk(5'd6, 3'd6, 3'd0, 5'd12, 32'h1, 32'h2, 32'h3, 32'h4, 5'b00011,
                     -1, 2, 1'b0, 0, 1'b0, 1'b0, 32'h0, 5'b00000);
    dir_tab[10] = mk(5'd1, 3'd3, 3'd0, 5'd13, 32'h40400000, 32'h3F800000, 32'h0, 32'h40000000, 5'b00001,
                     -1, 1, 1'b0, 2, 1'b1, 1'b0, 32'h40000000, 5'b00001);
    dir_tab[11] = mk(5'd6, 3'd0, 3'd0, 5'd14, 32'h5, 32'h6, 32'h0, 32'h6, 5'b00000,
                     -1, 3, 1'b0, 0, 1'b1, 1'b0, 32'h6, 5'b00000);
    dir_tab[12] = mk(5'd4, 3'd1, 3'd0, 5'd15, 32'h40800000, 32'h0, 32'h0, 32'h40000000, 5'b00001,
                     63, 0, 1'b0, 63, 1'b1, 1'b0, 32'h40000000, 5'b00001);

    repeat (3) @(posedge clk);
    #2 check_all_zero("reset");
    @(posedge clk); #1 Rst = 1'b1;
    #1 check_all_zero("post-reset");

    for (int i = 0; i < 13; i++) begin
      cur_id = i;
      run_vec(dir_tab[i]);
    end

    for (int i = 0; i < 40; i++) begin
      cur_id = 100 + i;
      rv.sel  = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(3, 4)) : 5'($urandom_range(0, 15));
      rv.frm  = 3'($urandom_range(0, 7));
      rv.fcsr = 3'($urandom_range(0, 7));
      rv.rd   = 5'($urandom_range(0, 31));
      rv.a = $urandom; rv.b = $urandom; rv.c = $urandom; rv.res = $urandom;
      rv.flags = 5'($urandom_range(0, 31));
      if (rv.sel == 5'd3 || rv.sel == 5'd4)
        rv.done_at = ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(0, 70));
      else
        rv.done_at = int'($urandom_range(0, 4));
      rv.hold = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 4)) : 0;
      rv.clr  = ($urandom_range(0, 5) == 0);
      rv = ref_model(rv);
      run_vec(rv);
    end

    // Reset asserted while an fmul is in BUSY: outputs must clear without waiting for an edge.
    cur_id = 200;
    @(posedge clk); #1;
    ID_EX_fpusrc = 1'b1; ID_EX_fpusel = 5'd2; ID_EX_frm = 3'd0; ID_EX_rd = 5'd20;
    ID_EX_dout_rs1 = 32'h40000000; ID_EX_dout_rs2 = 32'h40400000; ID_EX_dout_rs3 = 32'h0;
    fpu_done = 1'b0; mem_hold = 1'b0; fflags_clr = 1'b0; fpu_flags = 5'b00001;
    #1 check("rst-seq issue f_stall", f_stall, 1);
    @(posedge clk); #2;
    check("rst-seq fpu_start", fpu_start, 1);
    check("rst-seq busy f_stall", f_stall, 1);
    @(posedge clk); #1 Rst = 1'b0;
    #1 check_all_zero("mid-busy reset");
    @(posedge clk); #1 ID_EX_fpusrc = 1'b0;
    @(posedge clk); #1 Rst = 1'b1;
    m_acc = '0;
    cur_id = 201;
    run_vec(dir_tab[0]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/fp_ex_seq.md
Name: fp_ex_seq

Overview:
- Execute-stage FP sequencer, directly downstream of decode.
- Consumes the ID_EX_* FP controls and operands, issues each op to the external FP datapath, and generates f_stall back to decode.
- Registers the result, rd and fflags into the EX_MEM boundary.
- Fixed-latency ops are timed by an internal counter; fdiv and fsqrt complete on a done handshake, guarded by a timeout.

Parameters:
LAT_ADD, 3, cycles for fadd/fsub (fpusel 0,1)
LAT_MUL, 4, cycles for fmul/fmadd family (fpusel 2,8-11)
LAT_MISC, 1, cycles for all other fpusel codes (min/max/cvt/sgnj/cmp)
DIV_TIMEOUT, 64, max cycles to wait for fpu_done on fdiv (3) / fsqrt (4)

Ports:
clk  in  1  core clock
Rst  in  1  asynchronous, active-low reset
ID_EX_fpusrc  in  1  ID_EX holds a valid FP op
ID_EX_fpusel  in  5  FP op select
ID_EX_frm  in  3  rounding mode; 3'b111 = dynamic
ID_EX_rd  in  5  destination FP register
ID_EX_dout_rs1/rs2/rs3  in  32 each  operands
fcsr_frm  in  3  dynamic rounding mode from fcsr
mem_hold  in  1  global memory stall
fflags_clr  in  1  clear sticky flags
fpu_start  out  1  one-cycle issue pulse
fpu_op  out  5  registered fpusel
fpu_rm  out  3  resolved rounding mode
fpu_a/fpu_b/fpu_c  out  32 each  registered operands
fpu_res  in  32  datapath result
fpu_flags  in  5  NV,DZ,OF,UF,NX
fpu_done  in  1  completion for fdiv/fsqrt
f_stall  out  1  hold IF/ID/ID_EX
EX_MEM_fpures  out  32  result
EX_MEM_fprd  out  5  destination
EX_MEM_fpusrc  out  1  one-cycle FP regwrite strobe
fflags_acc  out  5  sticky accumulated flags
illegal_rm  out  1  pulse on reserved rounding mode
fpu_timeout  out  1  pulse on div/sqrt timeout

Behaviour:
- Reset (Rst=0, async): all outputs 0; state IDLE; counter 0.
- Rounding mode: rm = (ID_EX_frm==7) ? fcsr_frm : ID_EX_frm.
- issue = IDLE & ID_EX_fpusrc.
- FSM states: IDLE, BUSY, WAITD, HOLD.
- IDLE, issue:
  - Capture op, rm and operands into fpu_* registers; pulse fpu_start; load cnt = LAT-1 for the op class.
  - Go to BUSY (fixed-latency op) or WAITD (fdiv/fsqrt).
  - If LAT=1, finish in the same edge.
- Reserved rm (5/6 after resolution): no fpu_start; finish immediately with EX_MEM_fpusrc=0; pulse illegal_rm.
- BUSY: cnt decrements each cycle. Finishing cycle is cnt==1 (or the issue cycle when LAT=1). Result = fpu_res.
- WAITD: finishing cycle is fpu_done=1, result = fpu_res. If DIV_TIMEOUT cycles elapse without done: result 32'h7FC00000, flags NV, pulse fpu_timeout.
- f_stall (combinational) = (issue | BUSY | WAITD) & ~finishing.
  - Decode holds ID_EX until the finishing cycle; ID_EX advances on the same edge that registers the result.
  - A LAT=1 op therefore never stalls.
- Finish edge:
  - EX_MEM_fpures/EX_MEM_fprd load; EX_MEM_fpusrc=1 for one cycle.
  - fflags_acc |= flags.
  - Next state IDLE, or HOLD if mem_hold=1.
- HOLD: EX_MEM outputs frozen; EX_MEM_fpusrc stays 1; issue suppressed, so the held ID_EX op is not re-issued. Leave to IDLE when mem_hold=0.
- mem_hold during BUSY/WAITD: counting continues; the result is simply held afterwards.
- fflags_clr has priority over a same-cycle accumulate: flags = new flags only.
- fpu_done outside WAITD: ignored.

Optional Feature:
FP_FWD_EN:
- Defined: adds ports ID_EX_rs1/rs2/rs3 (5 each).
- At issue, any operand whose rs equals the previous op's EX_MEM_fprd, where the previous op wrote (its EX_MEM_fpusrc was asserted), is taken from EX_MEM_fpures instead of the ID_EX_dout value.
- Undefined: ports absent; operands always come from ID_EX_dout.

Test Plan:
1. fadd (fpusel=0, frm=0) a=0x3F800000, b=0x40000000, fpu_res=0x40400000 -> f_stall high 2 cycles; EX_MEM_fpures=0x40400000, EX_MEM_fprd=3, strobe 1 cycle on the 3rd edge.
2. fmax (fpusel=6) -> no stall; result registered next edge; fpu_start pulses once.
3. fdiv, fpu_done 10 cycles after start -> f_stall high exactly 10 cycles; fpu_done 1 cycle early or late shifts completion to match.
4. fsqrt, no fpu_done -> after 64 cycles result 0x7FC00000, fflags_acc[4]=1, fpu_timeout pulse.
5. frm=7, fcsr_frm=5 -> illegal_rm pulse, no fpu_start, EX_MEM_fpusrc=0.
6. fmul finishing with mem_hold=1 for 4 cycles -> single fpu_start, EX_MEM held; drive Rst=0 mid-BUSY -> all outputs 0 immediately.
